reset_sequencer: RTL
====================

// Module: reset_sequencer
// PURPOSE
//  Staged reset release, downstream of the active-low reset synchronizer.
//  Takes the synchronized platform reset (inverted to active-high) and the
//  clock-generator lock indicator, all in dest_clk.
//  Releases a peripheral-side reset first, then a core-side reset after a
//  fixed gap.
//  Re-asserts both immediately on lock loss and reports how often that happened.
// PARAMETERS
//  LOCK_FILTER  3   consecutive synced lock=1 samples required (>=1)
//  HOLD_CYCLES  16  cycles both resets stay asserted after lock qualifies (>=1)
//  STAGE_GAP    8   cycles between periph_resetn and core_resetn release (>=1)
// PORTS
//  dest_clk         in   1  sole clock
//  dest_rst         in   1  synchronous active-high reset
//  mmcm_locked      in   1  lock indicator, asynchronous; 2-flop synced inside
//  periph_resetn    out  1  active-low reset for peripherals/shell, registered
//  core_resetn      out  1  active-low reset for core logic, registered
//  seq_state        out  3  current FSM state (debug)
//  lock_loss_count  out  8  saturating count of lock losses seen in HOLD/GAP/RUN
// BEHAVIOUR
//  Reset values and outputs
//   - dest_rst=1 at an edge: state=RESET, periph_resetn=0, core_resetn=0.
//   - Same edge: lock_loss_count=0, all counters=0, sync flops=0.
//   - Every output is a flop; no combinational path from any input to an output.
//  Lock synchronizer
//   - lk = mmcm_locked delayed by 2 flops.
//   - Only lk is used by the FSM.
//  States (seq_state encoding)
//   - RESET(0), WAIT_LOCK(1), HOLD(2), GAP(3), RUN(4).
//  Transitions, evaluated each edge with dest_rst=0
//   - RESET: go to WAIT_LOCK unconditionally. Outputs stay 0.
//   - WAIT_LOCK
//     - Filter count fc increments while lk=1 and clears to 0 when lk=0.
//     - If lk=1 and fc==LOCK_FILTER-1: go to HOLD, clear cnt.
//     - Both resets stay 0.
//   - HOLD
//     - cnt increments.
//     - At cnt==HOLD_CYCLES-1: go to GAP, clear cnt, periph_resetn<=1 on this same edge.
//   - GAP
//     - cnt increments.
//     - At cnt==STAGE_GAP-1: go to RUN, core_resetn<=1 on this same edge.
//   - RUN: hold, both resets stay 1.
//  Lock loss (lk=0 in HOLD, GAP or RUN)
//   - Overrides every other transition.
//   - Next edge: state=WAIT_LOCK, periph_resetn=0, core_resetn=0, fc=0, cnt=0.
//   - lock_loss_count increments; it holds at 255.
//   - lk=0 while in WAIT_LOCK is not a loss and does not count.
//  Simultaneous events
//   - dest_rst beats lock loss.
//   - Lock loss beats counter terminal count.
//  Reset mid-operation
//   - dest_rst in any state: RESET values on that edge.
//   - The sequence restarts from RESET; there is no partial resume.
//  Latency, mmcm_locked steady high, counted from the first edge with dest_rst=0
//   - periph_resetn rises after 1+2+LOCK_FILTER+HOLD_CYCLES edges (sync latency included).
//   - core_resetn rises exactly STAGE_GAP edges after periph_resetn.
//  Invariant
//   - core_resetn=1 implies periph_resetn=1 at every cycle.
//  Counter width
//   - $clog2(max(HOLD_CYCLES,STAGE_GAP,LOCK_FILTER))+1 bits.
// TESTING  (LOCK_FILTER=3, HOLD_CYCLES=4, STAGE_GAP=2)
//  T1 Reset: dest_rst=1 for 5 cycles, mmcm_locked=1.
//     -> Both resets 0, seq_state=0, lock_loss_count=0 throughout.
//  T2 Normal bring-up: release dest_rst at edge E0, mmcm_locked=1 constant.
//     -> periph_resetn=1 at E10, core_resetn=1 at E12, seq_state=4 from E12.
//  T3 Lock glitch during filter: lk pattern 1,1,0,1,1,1 in WAIT_LOCK.
//     -> HOLD entered only after the final 3 ones; lock_loss_count stays 0.
//  T4 Lock loss in RUN: drop mmcm_locked for 1 cycle.
//     -> 3 edges later both resets 0, seq_state=1, lock_loss_count=1.
//     -> Re-release at +3+4 (periph) and +2 (core) edges after lk returns.
//  T5 Lock loss in GAP: periph_resetn=1, core_resetn=0, lk drops.
//     -> periph_resetn returns to 0, core_resetn never pulses high.
//  T6 dest_rst asserted in HOLD on the same edge cnt==3.
//     -> RESET wins, periph_resetn stays 0.
//  T7 Saturation: 260 lock losses.
//     -> lock_loss_count=255.
//  T8 All tests: assert core_resetn implies periph_resetn on every cycle.

Source files
------------

// File: rtl/reset_sequencer.sv
// Staged reset release for the dest_clk domain.
//
// Starts from the synchronized platform reset (active-high, synchronous) and the
// asynchronous clock-generator lock. The peripheral-side reset is released first,
// then the core-side reset after a fixed gap. Losing lock in HOLD, GAP or RUN
// puts both resets back immediately, restarts qualification and bumps a
// saturating loss counter.
//
// Ports
//   dest_clk         in   sole clock
//   dest_rst         in   synchronous active-high reset
//   mmcm_locked      in   lock indicator, asynchronous (2-flop synchronized here)
//   periph_resetn    out  active-low peripheral/shell reset, registered
//   core_resetn      out  active-low core reset, registered
//   seq_state        out  current FSM state (debug)
//   lock_loss_count  out  saturating count of lock losses seen in HOLD/GAP/RUN
module reset_sequencer #(
  parameter int unsigned LOCK_FILTER = 3,
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned STAGE_GAP   = 8
) (
  input  logic       dest_clk,
  input  logic       dest_rst,
  input  logic       mmcm_locked,
  output logic       periph_resetn,
  output logic       core_resetn,
  output logic [2:0] seq_state,
  output logic [7:0] lock_loss_count
);

  localparam int unsigned MaxHg  = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
  localparam int unsigned MaxCnt = (MaxHg > LOCK_FILTER) ? MaxHg : LOCK_FILTER;
  localparam int unsigned CntW   = $clog2(MaxCnt) + 1;

  localparam logic [CntW-1:0] FcLast   = CntW'(LOCK_FILTER - 1);
  localparam logic [CntW-1:0] HoldLast = CntW'(HOLD_CYCLES - 1);
  localparam logic [CntW-1:0] GapLast  = CntW'(STAGE_GAP - 1);

  typedef enum logic [2:0] {
    StReset    = 3'd0,
    StWaitLock = 3'd1,
    StHold     = 3'd2,
    StGap      = 3'd3,
    StRun      = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] fc_q, fc_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            periph_q, periph_d;
  logic            core_q, core_d;
  logic [7:0]      loss_q, loss_d;
  logic            sync1_q, lk_q;
  logic            lock_lost;

  // Lock synchronizer. Held clear while in RESET so lock sampling only starts
  // once the sequence has left RESET; the 2-flop latency then always adds to
  // the bring-up time instead of overlapping the RESET cycle.
  always_ff @(posedge dest_clk) begin
    if (dest_rst || (state_q == StReset)) begin
      sync1_q <= 1'b0;
      lk_q    <= 1'b0;
    end else begin
      sync1_q <= mmcm_locked;
      lk_q    <= sync1_q;
    end
  end

  // lk low in WAIT_LOCK is just "not yet locked", not a loss.
  assign lock_lost = !lk_q && ((state_q == StHold) || (state_q == StGap) ||
                               (state_q == StRun));

  always_comb begin
    state_d  = state_q;
    fc_d     = fc_q;
    cnt_d    = cnt_q;
    periph_d = periph_q;
    core_d   = core_q;
    loss_d   = loss_q;

    if (lock_lost) begin
      // Loss overrides any terminal count reached on the same edge.
      state_d  = StWaitLock;
      fc_d     = '0;
      cnt_d    = '0;
      periph_d = 1'b0;
      core_d   = 1'b0;
      if (loss_q != 8'hFF) begin
        loss_d = loss_q + 8'd1;
      end
    end else begin
      case (state_q)
        StReset: begin
          state_d  = StWaitLock;
          fc_d     = '0;
          cnt_d    = '0;
          periph_d = 1'b0;
          core_d   = 1'b0;
        end
        StWaitLock: begin
          periph_d = 1'b0;
          core_d   = 1'b0;
          if (lk_q) begin
            if (fc_q == FcLast) begin
              state_d = StHold;
              fc_d    = '0;
              cnt_d   = '0;
            end else begin
              fc_d = fc_q + CntW'(1);
            end
          end else begin
            fc_d = '0;
          end
        end
        StHold: begin
          if (cnt_q == HoldLast) begin
            state_d  = StGap;
            cnt_d    = '0;
            periph_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StGap: begin
          if (cnt_q == GapLast) begin
            state_d = StRun;
            cnt_d   = '0;
            core_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StRun: begin
          periph_d = 1'b1;
          core_d   = 1'b1;
        end
        default: begin
          state_d  = StReset;
          periph_d = 1'b0;
          core_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge dest_clk) begin
    if (dest_rst) begin
      state_q  <= StReset;
      fc_q     <= '0;
      cnt_q    <= '0;
      periph_q <= 1'b0;
      core_q   <= 1'b0;
      loss_q   <= 8'd0;
    end else begin
      state_q  <= state_d;
      fc_q     <= fc_d;
      cnt_q    <= cnt_d;
      periph_q <= periph_d;
      core_q   <= core_d;
      loss_q   <= loss_d;
    end
  end

  assign periph_resetn   = periph_q;
  assign core_resetn     = core_q;
  assign seq_state       = state_q;
  assign lock_loss_count = loss_q;

endmodule
